// File: rtl/mem_fifo_pkg.sv
// Shared sizing, types and pointer helper for the 1R1W memory FIFO controller.
`default_nettype none

package mem_fifo_pkg;

  localparam int DEPTH   = 48;
  localparam int WIDTH   = 64;
  localparam int ADDR_W  = $clog2(DEPTH);
  localparam int LEVEL_W = $clog2(DEPTH + 3);
  localparam int CNT_W   = $clog2(DEPTH + 1);

  typedef logic [ADDR_W-1:0] ptr_t;
  typedef logic [WIDTH-1:0]  word_t;

  // DEPTH need not be a power of two, so wrap by compare rather than truncation
  function automatic ptr_t next_ptr(input ptr_t ptr);
    return (ptr == ptr_t'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_1r1w_fifo_ctrl_if.sv
// Ready/valid word stream; master drives valid/data, slave drives ready.
`default_nettype none

interface mem_1r1w_fifo_ctrl_if #(
  parameter int WIDTH = 64
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

`default_nettype wire

// File: rtl/mem_1r1w_fifo_ctrl_out_buf.sv
// Two-entry head/tail output queue that absorbs the memory read latency.
`default_nettype none

module mem_fifo_out_buf #(
  parameter int WIDTH = 64
) (
  input  wire logic             clock,
  input  wire logic             reset_n,
  input  wire logic             i_flush,
  input  wire logic             i_push,
  input  wire logic [WIDTH-1:0] i_push_data,
  input  wire logic             i_pop,
  output logic      [1:0]       o_occ,
  output logic      [WIDTH-1:0] o_head_data
);

  logic [WIDTH-1:0] r_mem [2];
  logic [1:0]       r_occ;
  logic             r_head;
  logic             w_tail;

  assign w_tail      = r_head ^ r_occ[0];
  assign o_occ       = r_occ;
  assign o_head_data = r_mem[r_head];

  // Push only ever arrives with a free slot (occ <= 1), so tail = head + occ
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_occ    <= '0;
      r_head   <= 1'b0;
    end else if (i_flush) begin
      r_occ  <= '0;
      r_head <= 1'b0;
    end else begin
      if (i_push) r_mem[w_tail] <= i_push_data;
      if (i_pop)  r_head        <= ~r_head;
      r_occ <= r_occ + 2'(i_push) - 2'(i_pop);
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_1r1w_fifo_ctrl.sv
// Turns a 1-cycle-latency 1R1W memory into a ready/valid FIFO of DEPTH+2 words.
`default_nettype none

module mem_1r1w_fifo_ctrl
  import mem_fifo_pkg::*;
#(
  parameter int DEPTH   = mem_fifo_pkg::DEPTH,
  parameter int WIDTH   = mem_fifo_pkg::WIDTH,
  parameter int ADDR_W  = mem_fifo_pkg::ADDR_W,
  parameter int LEVEL_W = mem_fifo_pkg::LEVEL_W
) (
  input  wire logic               clock,
  input  wire logic               reset_n,
  input  wire logic               flush,
  mem_1r1w_fifo_ctrl_if.slave     enq,
  mem_1r1w_fifo_ctrl_if.master    deq,
  output logic      [LEVEL_W-1:0] level,
  output logic      [ADDR_W-1:0]  mem_W0_addr,
  output logic                    mem_W0_en,
  output logic      [WIDTH-1:0]   mem_W0_data,
  output logic      [ADDR_W-1:0]  mem_R0_addr,
  output logic                    mem_R0_en,
  input  wire logic [WIDTH-1:0]   mem_R0_data
);

  localparam int C_CNT_W = $clog2(DEPTH + 1);

  ptr_t               r_wptr;
  ptr_t               r_rptr;
  logic [C_CNT_W-1:0] r_mem_cnt;
  logic               r_rd_pend;

  logic               w_enq_ready;
  logic               w_enq_fire;
  logic               w_deq_fire;
  logic               w_rd_issue;
  logic [2:0]         w_inflight;
  logic [1:0]         w_out_occ;
  logic [WIDTH-1:0]   w_head_data;

  assign w_enq_ready = reset_n & (r_mem_cnt != C_CNT_W'(DEPTH)) & ~flush;
  assign w_enq_fire  = enq.valid & w_enq_ready;
  assign w_deq_fire  = deq.valid & deq.ready;

  // Issue only if the word still fits in the output buffer after this cycle's dequeue
  assign w_inflight  = {1'b0, w_out_occ} + {2'b00, r_rd_pend};
  assign w_rd_issue  = (r_mem_cnt != '0)
                     & (w_inflight < (3'd2 + {2'b00, w_deq_fire}))
                     & ~flush;

  assign enq.ready   = w_enq_ready;
  assign mem_W0_en   = w_enq_fire;
  assign mem_W0_addr = r_wptr;
  assign mem_W0_data = enq.data;
  assign mem_R0_en   = w_rd_issue;
  assign mem_R0_addr = r_rptr;

  assign deq.valid   = (w_out_occ != 2'd0);
  assign deq.data    = w_head_data;
  assign level       = LEVEL_W'(r_mem_cnt) + LEVEL_W'(r_rd_pend) + LEVEL_W'(w_out_occ);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_mem_cnt <= '0;
      r_rd_pend <= 1'b0;
    end else if (flush) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_mem_cnt <= '0;
      r_rd_pend <= 1'b0;
    end else begin
      if (w_enq_fire) r_wptr <= next_ptr(r_wptr);
      if (w_rd_issue) r_rptr <= next_ptr(r_rptr);
      r_mem_cnt <= r_mem_cnt + C_CNT_W'(w_enq_fire) - C_CNT_W'(w_rd_issue);
      r_rd_pend <= w_rd_issue;
    end
  end

  mem_fifo_out_buf #(
    .WIDTH (WIDTH)
  ) u_out_buf (
    .clock       (clock),
    .reset_n     (reset_n),
    .i_flush     (flush),
    .i_push      (r_rd_pend),
    .i_push_data (mem_R0_data),
    .i_pop       (w_deq_fire),
    .o_occ       (w_out_occ),
    .o_head_data (w_head_data)
  );

endmodule

`default_nettype wire

// File: tb/tb_mem_1r1w_fifo_ctrl.sv
// Randomised bench for mem_1r1w_fifo_ctrl against a queue-based FIFO model.
`default_nettype none

module tb_mem_1r1w_fifo_ctrl;

  localparam int DEPTH   = 48;
  localparam int WIDTH   = 64;
  localparam int ADDR_W  = 6;
  localparam int LEVEL_W = 6;

  logic               clock;
  logic               reset_n;
  logic               flush;
  logic [LEVEL_W-1:0] level;
  logic [ADDR_W-1:0]  mem_W0_addr;
  logic               mem_W0_en;
  logic [WIDTH-1:0]   mem_W0_data;
  logic [ADDR_W-1:0]  mem_R0_addr;
  logic               mem_R0_en;
  logic [WIDTH-1:0]   mem_R0_data;

  mem_1r1w_fifo_ctrl_if #(.WIDTH(WIDTH)) enq_if ();
  mem_1r1w_fifo_ctrl_if #(.WIDTH(WIDTH)) deq_if ();

  mem_1r1w_fifo_ctrl dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .flush       (flush),
    .enq         (enq_if),
    .deq         (deq_if),
    .level       (level),
    .mem_W0_addr (mem_W0_addr),
    .mem_W0_en   (mem_W0_en),
    .mem_W0_data (mem_W0_data),
    .mem_R0_addr (mem_R0_addr),
    .mem_R0_en   (mem_R0_en),
    .mem_R0_data (mem_R0_data)
  );

  // Behavioural stand-in for the mem_1r1w macro: registered read
  logic [WIDTH-1:0] mem_array [DEPTH];
  always @(posedge clock) begin
    if (mem_W0_en) mem_array[mem_W0_addr] <= mem_W0_data;
    if (mem_R0_en) mem_R0_data <= mem_array[mem_R0_addr];
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: all words held in order; m_out of them sit in the output buffer,
  // m_pend are in flight from the memory, the rest are still in memory.
  logic [WIDTH-1:0] m_q [$];
  int m_out, m_pend, m_wp, m_rp;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    m_out  = 0;
    m_pend = 0;
    m_wp   = 0;
    m_rp   = 0;
  endtask

  task automatic check_and_advance();
    int memw;
    bit e_rdy, e_fire, e_dv, d_fire, e_iss;
    memw   = m_q.size() - m_out - m_pend;
    e_rdy  = (memw != DEPTH) && !flush;
    e_fire = enq_if.valid && e_rdy;
    e_dv   = (m_out > 0);
    d_fire = e_dv && deq_if.ready;
    e_iss  = (memw != 0) && ((m_out + m_pend - int'(d_fire)) < 2) && !flush;

    cmp("enq_ready", 64'(enq_if.ready), 64'(e_rdy));
    cmp("deq_valid", 64'(deq_if.valid), 64'(e_dv));
    cmp("level", 64'(level), 64'(m_q.size()));
    cmp("W0_en", 64'(mem_W0_en), 64'(e_fire));
    cmp("R0_en", 64'(mem_R0_en), 64'(e_iss));
    if (e_dv) cmp("deq_data", deq_if.data, m_q[0]);
    if (e_fire) begin
      cmp("W0_addr", 64'(mem_W0_addr), 64'(m_wp));
      cmp("W0_data", mem_W0_data, enq_if.data);
    end
    if (e_iss) cmp("R0_addr", 64'(mem_R0_addr), 64'(m_rp));
    if (mem_W0_en && mem_R0_en)
      cmp("rw_collision", 64'(mem_W0_addr == mem_R0_addr), 64'd0);

    if (flush) begin
      model_clear();
    end else begin
      if (d_fire) void'(m_q.pop_front());
      m_out  = m_out + m_pend - int'(d_fire);
      m_pend = int'(e_iss);
      if (e_fire) begin
        m_q.push_back(enq_if.data);
        m_wp = (m_wp + 1) % DEPTH;
      end
      if (e_iss) m_rp = (m_rp + 1) % DEPTH;
    end
  endtask

  // Inputs change at posedge+1; the model is checked and stepped at the negedge
  task automatic step();
    @(negedge clock);
    check_and_advance();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int acc, idx, seen;
    logic [WIDTH-1:0] first;
    int p_enq, p_deq;

    reset_n      = 1'b0;
    flush        = 1'b0;
    enq_if.valid = 1'b0;
    enq_if.data  = '0;
    deq_if.ready = 1'b0;
    model_clear();
    #1;
    cmp("rst_deq_valid", 64'(deq_if.valid), 64'd0);
    cmp("rst_level", 64'(level), 64'd0);
    cmp("rst_enq_ready", 64'(enq_if.ready), 64'd0);
    cmp("rst_R0_en", 64'(mem_R0_en), 64'd0);
    cmp("rst_W0_en", 64'(mem_W0_en), 64'd0);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;

    // Single word latency
    enq_if.valid = 1'b1;
    enq_if.data  = 64'hA5;
    deq_if.ready = 1'b1;
    step();
    enq_if.valid = 1'b0;
    #1;
    cmp("lat_R0_en_c1", 64'(mem_R0_en), 64'd1);
    cmp("lat_level_c1", 64'(level), 64'd1);
    step();
    #1;
    cmp("lat_level_c2", 64'(level), 64'd1);
    cmp("lat_valid_c2", 64'(deq_if.valid), 64'd0);
    step();
    #1;
    cmp("lat_valid_c3", 64'(deq_if.valid), 64'd1);
    cmp("lat_data_c3", deq_if.data, 64'hA5);
    cmp("lat_level_c3", 64'(level), 64'd1);
    step();
    #1;
    cmp("lat_level_c4", 64'(level), 64'd0);

    // Fill to capacity with the consumer stalled
    deq_if.ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 61; i++) begin
      enq_if.valid = 1'b1;
      enq_if.data  = 64'(acc);
      #1;
      if (enq_if.ready) acc++;
      step();
    end
    enq_if.valid = 1'b0;
    cmp("full_accepted", 64'(acc), 64'd50);
    #1;
    cmp("full_enq_ready", 64'(enq_if.ready), 64'd0);
    cmp("full_level", 64'(level), 64'd50);
    step();

    deq_if.ready = 1'b1;
    idx = 0;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (deq_if.valid) begin
        cmp("drain_order", deq_if.data, 64'(idx));
        idx++;
      end
      step();
    end
    cmp("drain_count", 64'(idx), 64'd50);

    // Streaming across several pointer wraps
    for (int i = 0; i < 200; i++) begin
      enq_if.valid = 1'b1;
      enq_if.data  = 64'(1000 + i);
      step();
    end
    enq_if.valid = 1'b0;
    repeat (5) step();

    // Flush with a full output buffer and ten words in memory
    deq_if.ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      enq_if.valid = 1'b1;
      enq_if.data  = 64'(500 + i);
      step();
    end
    enq_if.valid = 1'b0;
    repeat (4) step();
    #1;
    cmp("preflush_level", 64'(level), 64'd12);
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    cmp("flush_level", 64'(level), 64'd0);
    cmp("flush_deq_valid", 64'(deq_if.valid), 64'd0);
    enq_if.valid = 1'b1;
    enq_if.data  = 64'h77;
    step();
    enq_if.valid = 1'b0;
    deq_if.ready = 1'b1;
    seen  = 0;
    first = '0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (deq_if.valid && seen == 0) begin
        first = deq_if.data;
        seen  = 1;
      end
      step();
    end
    cmp("post_flush_seen", 64'(seen), 64'd1);
    cmp("post_flush_first", first, 64'h77);

    // Asynchronous reset pulse between clock edges mid-stream
    for (int i = 0; i < 20; i++) begin
      enq_if.valid = 1'b1;
      enq_if.data  = 64'(2000 + i);
      step();
    end
    #1;
    reset_n = 1'b0;
    #1;
    cmp("arst_deq_valid", 64'(deq_if.valid), 64'd0);
    cmp("arst_R0_en", 64'(mem_R0_en), 64'd0);
    cmp("arst_level", 64'(level), 64'd0);
    cmp("arst_enq_ready", 64'(enq_if.ready), 64'd0);
    #1;
    reset_n = 1'b1;
    model_clear();
    step();

    // Random traffic with occasional flushes
    p_enq = 50;
    p_deq = 50;
    for (int i = 0; i < 10000; i++) begin
      if (i % 1000 == 0) begin
        p_enq = int'($urandom_range(10, 95));
        p_deq = int'($urandom_range(10, 95));
      end
      enq_if.valid = ($urandom_range(0, 99) < p_enq);
      enq_if.data  = {$urandom(), $urandom()};
      deq_if.ready = ($urandom_range(0, 99) < p_deq);
      flush        = ($urandom_range(0, 299) == 0);
      step();
    end
    flush        = 1'b0;
    enq_if.valid = 1'b0;
    deq_if.ready = 1'b1;
    repeat (60) step();
    #1;
    cmp("final_level", 64'(level), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
